// File: rtl/serial_frontend_pkg.sv
// Shared types for the serial front end: FSM state encoding and a width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_frontend_pkg;

    // Frame state: IDLE waits for csn to fall, ACTIVE accepts sample edges.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } fe_state_e;

    // Bit-counter width for a WIDTH-bit word (counts 0..WIDTH-1).
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_frontend_if.sv
// Pin-side inputs and shift-register-side strobes of the serial front end.
// Latency: n/a (wiring only).
// Backpressure: none; strobes are fire-and-forget, the consumer must take every one.
interface serial_frontend_if
    import serial_frontend_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CW = cnt_width(WIDTH);

    // external asynchronous pins
    logic          sclk;
    logic          sdata;
    logic          csn;

    // strobes towards the downstream shift register
    logic          advance;
    logic          data_bit;
    logic          clear;
    logic          word_valid;
    logic          frame_err;
    logic [CW-1:0] bit_count;

    // the front end itself
    modport master (
        input  sclk, sdata, csn,
        output advance, data_bit, clear, word_valid, frame_err, bit_count
    );

    // pin driver / strobe consumer
    modport slave (
        output sclk, sdata, csn,
        input  advance, data_bit, clear, word_valid, frame_err, bit_count
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous pin plus a history flop for edge detection.
// Latency: STAGES cycles pin->level_o; rise_o/fall_o are combinational on level vs. history.
// Backpressure: none.
module sync_edge_detect #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Shift the pin through the synchroniser chain, then keep one cycle of history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  =  level_o & ~hist_q;
    assign fall_o  = ~level_o &  hist_q;

endmodule

// File: rtl/serial_frontend.sv
// Synchronises sclk/sdata/csn, frames WIDTH-bit words and strobes the downstream shift register.
// Latency: pin edge to advance/clear/frame_err = SYNC_STAGES+1 cycles; word_valid one cycle after the last advance.
// Backpressure: none; the shift register must accept every advance and clear.
module serial_frontend
    import serial_frontend_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int SAMPLE_RISING = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    serial_frontend_if.master bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic       sclk_lvl, sclk_rise, sclk_fall;
    logic       csn_lvl, csn_rise, csn_fall;
    logic       sdata_lvl;
    logic [1:0] sdata_edges_unused;
    logic       csn_lvl_unused;
    logic       samp_edge;

    // sclk and sdata share the same chain depth so the sampled bit lines up with its edge.
    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (bus.sclk),
        .level_o(sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // csn resets inactive so a pin held low through reset yields a fresh frame start.
    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (bus.csn),
        .level_o(csn_lvl_unused),
        .rise_o (csn_rise),
        .fall_o (csn_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdata (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (bus.sdata),
        .level_o(sdata_lvl),
        .rise_o (sdata_edges_unused[0]),
        .fall_o (sdata_edges_unused[1])
    );

    assign csn_lvl   = csn_lvl_unused;
    assign samp_edge = (SAMPLE_RISING != 0) ? sclk_rise : sclk_fall;

    fe_state_e     state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          advance_q, advance_n;
    logic          bit_q, bit_n;
    logic          clear_q, clear_n;
    logic          frame_err_q, frame_err_n;
    logic          wv_pend_q, wv_pend_n;
    logic          word_valid_q;

    // Next state and next strobes; csn rise takes priority over a coincident sample edge.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        advance_n   = 1'b0;
        bit_n       = 1'b0;
        clear_n     = 1'b0;
        frame_err_n = 1'b0;
        wv_pend_n   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_n = '0;
                if (csn_fall) begin
                    state_n = ST_ACTIVE;
                    clear_n = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (csn_rise) begin
                    state_n     = ST_IDLE;
                    frame_err_n = (cnt_q != '0);
                    cnt_n       = '0;
                end else if (samp_edge) begin
                    advance_n = 1'b1;
                    bit_n     = sdata_lvl;
                    if (cnt_q == LAST_BIT) begin
                        cnt_n     = '0;
                        wv_pend_n = 1'b1;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State, counter and registered strobes; word_valid trails the final advance by one
    // cycle so it coincides with the shift register holding the full word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            advance_q    <= 1'b0;
            bit_q        <= 1'b0;
            clear_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            wv_pend_q    <= 1'b0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            advance_q    <= advance_n;
            bit_q        <= bit_n;
            clear_q      <= clear_n;
            frame_err_q  <= frame_err_n;
            wv_pend_q    <= wv_pend_n;
            word_valid_q <= wv_pend_q;
        end
    end

    assign bus.advance    = advance_q;
    assign bus.data_bit   = bit_q;
    assign bus.clear      = clear_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.word_valid = word_valid_q;
    assign bus.bit_count  = cnt_q;

endmodule

// File: tb/tb_serial_frontend.sv
// Scoreboard bench: expected bits/words queued as pins are driven, compared when strobes appear.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_frontend;

    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    int adv_cnt  = 0;
    int clr_cnt  = 0;
    int wv_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;

    logic [WIDTH-1:0] sr_model;
    logic             bitq[$];
    logic [WIDTH-1:0] wordq[$];

    serial_frontend_if #(.WIDTH(WIDTH)) sf ();

    serial_frontend #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (2),
        .SAMPLE_RISING(1)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (sf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream shift register model: clear wins, otherwise shift MSB first on advance.
    always @(posedge clk) begin
        if (sf.clear)
            sr_model <= '0;
        else if (sf.advance)
            sr_model <= {sr_model[WIDTH-2:0], sf.data_bit};
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sf.advance) begin
                adv_cnt++;
                if (bitq.size() == 0) chk("bit_unexpected", 32'd1, 32'd0);
                else                  chk("bit", {31'd0, sf.data_bit}, {31'd0, bitq.pop_front()});
            end
            if (sf.word_valid) begin
                wv_cnt++;
                if (wordq.size() == 0) chk("word_unexpected", 32'd1, 32'd0);
                else                   chk("word", {24'd0, sr_model}, {24'd0, wordq.pop_front()});
            end
            if (sf.clear)                 clr_cnt++;
            if (sf.frame_err)             fe_cnt++;
            if (sf.clear && sf.advance)   both_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One sclk period carrying bit b; sdata settles 4 cycles before the rising edge.
    task automatic send_bit(input logic b, input logic expect_it);
        @(negedge clk);
        sf.sdata = b;
        if (expect_it) bitq.push_back(b);
        idle(4);
        sf.sclk = 1'b1;
        idle(4);
        sf.sclk = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        wordq.push_back(w);
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i], 1'b1);
    endtask

    task automatic csn_low;
        @(negedge clk);
        sf.csn = 1'b0;
        idle(8);
    endtask

    task automatic csn_high;
        @(negedge clk);
        sf.csn = 1'b1;
        idle(8);
    endtask

    int a0, c0, w0, f0;
    task automatic snap;
        a0 = adv_cnt; c0 = clr_cnt; w0 = wv_cnt; f0 = fe_cnt;
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        sf.sclk  = 1'b0;
        sf.sdata = 1'b0;
        sf.csn   = 1'b1;
        rst_n    = 1'b0;
        sr_model = '0;
        idle(3);
        chk("rst_advance",    {31'd0, sf.advance},    32'd0);
        chk("rst_clear",      {31'd0, sf.clear},      32'd0);
        chk("rst_word_valid", {31'd0, sf.word_valid}, 32'd0);
        chk("rst_frame_err",  {31'd0, sf.frame_err},  32'd0);
        chk("rst_bit_count",  {29'd0, sf.bit_count},  32'd0);
        rst_n = 1'b1;
        idle(6);

        // single word 0xA5
        snap();
        csn_low();
        send_word(8'hA5);
        idle(4);
        chk("a5_bit_count", {29'd0, sf.bit_count}, 32'd0);
        csn_high();
        chk("a5_clear",   clr_cnt - c0, 1);
        chk("a5_advance", adv_cnt - a0, 8);
        chk("a5_words",   wv_cnt  - w0, 1);
        chk("a5_ferr",    fe_cnt  - f0, 0);

        // two back-to-back words in one frame
        snap();
        csn_low();
        send_word(8'h3C);
        send_word(8'hC3);
        idle(4);
        csn_high();
        chk("two_clear",   clr_cnt - c0, 1);
        chk("two_advance", adv_cnt - a0, 16);
        chk("two_words",   wv_cnt  - w0, 2);
        chk("two_ferr",    fe_cnt  - f0, 0);

        // partial word of 5 bits
        snap();
        csn_low();
        w = 8'b10110000;
        for (int i = 7; i >= 3; i--) send_bit(w[i], 1'b1);
        idle(4);
        chk("part_bit_count", {29'd0, sf.bit_count}, 32'd5);
        csn_high();
        chk("part_advance",  adv_cnt - a0, 5);
        chk("part_ferr",     fe_cnt  - f0, 1);
        chk("part_words",    wv_cnt  - w0, 0);
        chk("part_count_0",  {29'd0, sf.bit_count}, 32'd0);

        // sclk toggling while deselected
        snap();
        for (int i = 0; i < 10; i++) send_bit(i[0], 1'b0);
        idle(6);
        chk("idle_advance", adv_cnt - a0, 0);
        chk("idle_clear",   clr_cnt - c0, 0);
        chk("idle_words",   wv_cnt  - w0, 0);

        // reset mid-frame after 3 bits, csn held low
        snap();
        csn_low();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
        idle(4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_advance",   {31'd0, sf.advance},   32'd0);
        chk("mid_rst_clear",     {31'd0, sf.clear},     32'd0);
        chk("mid_rst_bit_count", {29'd0, sf.bit_count}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(8);
        chk("mid_rst_reclear", clr_cnt - c0, 2);
        send_word(8'h81);
        idle(4);
        csn_high();
        chk("mid_rst_words", wv_cnt - w0, 1);
        chk("mid_rst_ferr",  fe_cnt - f0, 0);

        // csn rise coincident with the 8th sample edge
        snap();
        csn_low();
        w = 8'h5A;
        for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b1);
        @(negedge clk);
        sf.sdata = w[0];
        idle(4);
        sf.sclk = 1'b1;
        sf.csn  = 1'b1;
        idle(4);
        sf.sclk = 1'b0;
        idle(8);
        chk("race_advance", adv_cnt - a0, 7);
        chk("race_ferr",    fe_cnt  - f0, 1);
        chk("race_words",   wv_cnt  - w0, 0);
        chk("race_count_0", {29'd0, sf.bit_count}, 32'd0);

        chk("clear_with_advance", both_cnt, 0);
        chk("bitq_empty",  bitq.size(),  0);
        chk("wordq_empty", wordq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
